// File: rtl/tlm_fifo.sv
// -----------------------------------------------------------------------------
// tlm_fifo
//
// Synchronous FIFO channel between a producer (put port) and a consumer (get
// port). Both sides use valid/ready handshakes. Words come out in the order
// they went in. The channel also reports its occupancy: used, empty and full.
//
// Parameters
//   WIDTH      bit width of one stored transaction word (default 65)
//   DEPTH      number of entries; any integer >= 1 (need not be a power of 2)
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   reset      synchronous, active-high reset
//   flush      (TLM_FIFO_FLUSH_EN only) synchronous discard of all contents
//   put_data   word offered by the producer
//   put_valid  producer has a word on put_data
//   put_ready  FIFO accepts a word this cycle (not full, not in reset)
//   get_data   head-of-queue word (first-word-fall-through)
//   get_valid  get_data holds a valid word (not empty, not in reset)
//   get_ready  consumer takes the head word this cycle
//   used       number of stored words
//   empty      used == 0
//   full       used == DEPTH
//
// Build option
//   TLM_FIFO_FLUSH_EN  when defined, adds the flush input. Without it the
//                      FIFO empties only through gets or reset.
// -----------------------------------------------------------------------------
module tlm_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef TLM_FIFO_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic [WIDTH-1:0]             put_data,
  input  logic                         put_valid,
  output logic                         put_ready,
  output logic [WIDTH-1:0]             get_data,
  output logic                         get_valid,
  input  logic                         get_ready,
  output logic [$clog2(DEPTH+1)-1:0]   used,
  output logic                         empty,
  output logic                         full
);

  // A one-entry FIFO still needs a one-bit pointer so that the port widths
  // stay legal. That pointer never leaves 0.
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int USED_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [USED_W-1:0] USED_FULL = USED_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [USED_W-1:0] used_q,   used_d;

  logic full_w;
  logic empty_w;
  logic put_fire;
  logic get_fire;
  logic flush_w;

`ifdef TLM_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Status and handshakes
  // ---------------------------------------------------------------------------
  // Occupancy comes only from the registered used count. Reset also gates both
  // ready and valid, because handshakes must be ignored while reset is high.
  assign full_w    = (used_q == USED_FULL);
  assign empty_w   = (used_q == '0);

  // A full FIFO refuses a put even when a get fires in the same cycle. This
  // keeps put_ready independent of get_ready, so the outputs have no
  // combinational path from the consumer's inputs.
  assign put_ready = !full_w  && !reset;
  assign get_valid = !empty_w && !reset;

  assign put_fire  = put_valid && put_ready;
  assign get_fire  = get_valid && get_ready;

  assign used      = used_q;
  assign empty     = empty_w;
  assign full      = full_w;

  // First-word-fall-through: the head entry is always presented. When the
  // FIFO is empty it holds stale data, which get_valid masks.
  assign get_data  = mem_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Pointer increment with wrap at DEPTH-1. An explicit compare is needed
  // because DEPTH need not be a power of two.
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is given a default first. A path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    used_d   = used_q;

    if (flush_w) begin
      // A flush discards the contents and any put or get in the same cycle.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      used_d   = '0;
    end else begin
      if (put_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (get_fire) rd_ptr_d = ptr_inc(rd_ptr_q);

      // A simultaneous put and get leave the count unchanged.
      unique case ({put_fire, get_fire})
        2'b10:   used_d = used_q + 1'b1;
        2'b01:   used_d = used_q - 1'b1;
        default: used_d = used_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers. Reset is synchronous and takes priority over flush.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      used_q   <= used_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately left out of reset. Its contents are
  // never observed until written, and leaving out the reset allows it to map
  // onto RAM or a plain flop array with no reset fan-out.
  always_ff @(posedge clk) begin
    if (put_fire && !flush_w) begin
      mem_q[wr_ptr_q] <= put_data;
    end
  end

endmodule

// File: tb/tb_tlm_fifo.sv
// -----------------------------------------------------------------------------
// tb_tlm_fifo
//
// Self-checking bench for tlm_fifo (WIDTH=65, DEPTH=4).
//
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// on the falling edge. A queue acts as both scoreboard and reference model:
//   - an accepted put pushes its word onto the queue;
//   - a fired get pops the expected word and compares it with get_data;
//   - used, empty, full, put_ready and get_valid are predicted from the queue
//     size.
// The FIFO's own outputs are never used to decide what happens next.
// -----------------------------------------------------------------------------
module tb_tlm_fifo;

  localparam int WIDTH  = 65;
  localparam int DEPTH  = 4;
  localparam int USED_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic [WIDTH-1:0]  put_data;
  logic              put_valid;
  logic              put_ready;
  logic [WIDTH-1:0]  get_data;
  logic              get_valid;
  logic              get_ready;
  logic [USED_W-1:0] used;
  logic              empty;
  logic              full;

  logic [WIDTH-1:0] model_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tlm_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef TLM_FIFO_FLUSH_EN
    .flush     (flush),
`endif
    .put_data  (put_data),
    .put_valid (put_valid),
    .put_ready (put_ready),
    .get_data  (get_data),
    .get_valid (get_valid),
    .get_ready (get_ready),
    .used      (used),
    .empty     (empty),
    .full      (full)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // Compare the status outputs with the model. When the model holds a word,
  // also compare get_data with the head word.
  task automatic check_status(input string tag);
    int sz = model_q.size();
    check({tag, ".used"},      WIDTH'(used),      WIDTH'(sz));
    check({tag, ".empty"},     WIDTH'(empty),     WIDTH'(sz == 0));
    check({tag, ".full"},      WIDTH'(full),      WIDTH'(sz == DEPTH));
    check({tag, ".put_ready"}, WIDTH'(put_ready), WIDTH'(sz < DEPTH));
    check({tag, ".get_valid"}, WIDTH'(get_valid), WIDTH'(sz > 0));
    if (sz > 0) check({tag, ".head"}, get_data, model_q[0]);
  endtask

  // Run one clock cycle with the given put/get stimulus.
  task automatic step(input string tag, input logic pv, input logic [WIDTH-1:0] pd,
                      input logic gr);
    bit exp_put, exp_get;
    logic [WIDTH-1:0] exp_word;
    put_valid = pv;
    put_data  = pd;
    get_ready = gr;
    @(negedge clk);
    check_status(tag);
    exp_put = pv && (model_q.size() < DEPTH);
    exp_get = gr && (model_q.size() > 0);
    if (exp_get) begin
      exp_word = model_q.pop_front();
      check({tag, ".get_data"}, get_data, exp_word);
    end
    if (exp_put) model_q.push_back(pd);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset     = 1'b1;
    put_valid = 1'b1;
    put_data  = 65'h1234;
    get_ready = 1'b1;
    @(negedge clk);
    check({tag, ".rst_put_ready"}, WIDTH'(put_ready), '0);
    check({tag, ".rst_get_valid"}, WIDTH'(get_valid), '0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    put_valid = 1'b0;
    get_ready = 1'b0;
    model_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    put_valid = 1'b0;
    put_data  = '0;
    get_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Idle after reset.
    step("idle", 1'b0, '0, 1'b0);

    // Single word: it becomes visible in the cycle after the put.
    step("put1", 1'b1, 65'h1_0000_0000_0000_0001, 1'b0);
    step("fwft", 1'b0, '0, 1'b0);
    step("get1", 1'b0, '0, 1'b1);

    // Fill to full. A fifth put is refused.
    for (int i = 1; i <= 4; i++) step("fill", 1'b1, WIDTH'(i), 1'b0);
    step("over", 1'b1, WIDTH'(5), 1'b0);
    // While full, a put is still refused when a get fires in the same cycle.
    step("full_pg", 1'b1, WIDTH'(6), 1'b1);
    step("refill", 1'b1, WIDTH'(7), 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1);
    step("under", 1'b0, '0, 1'b1);

    // Put and get every cycle over pointer wrap: used stays at 1.
    for (int i = 0; i < 10; i++)
      step("stream", 1'b1, {1'b1, 64'hA5A5_0000_0000_0000 + 64'(i)}, 1'b1);
    step("stream_end", 1'b0, '0, 1'b1);

    // Reset mid-stream with three words stored. They must never come back.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, WIDTH'(100 + i), 1'b0);
    step("pre_rst_chk", 1'b0, '0, 1'b0);
    do_reset("mid_rst");
    step("post_rst", 1'b0, '0, 1'b0);
    step("post_put", 1'b1, WIDTH'(200), 1'b0);
    step("post_get", 1'b0, '0, 1'b1);
    step("post_idle", 1'b0, '0, 1'b0);

`ifdef TLM_FIFO_FLUSH_EN
    // Flush with two words stored. The put of 7 in the same cycle is dropped.
    step("pre_fl", 1'b1, WIDTH'(11), 1'b0);
    step("pre_fl", 1'b1, WIDTH'(12), 1'b0);
    flush     = 1'b1;
    put_valid = 1'b1;
    put_data  = WIDTH'(7);
    get_ready = 1'b1;
    @(negedge clk);
    check_status("flush_cyc");
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_q.delete();
    step("post_fl", 1'b0, '0, 1'b0);
    step("post_fl2", 1'b1, WIDTH'(8), 1'b0);
    step("post_fl3", 1'b0, '0, 1'b1);
`endif

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)),
           {1'($urandom), 32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)));
    for (int i = 0; i < DEPTH + 1; i++) step("rand_drain", 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
